// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// fetch and hands one instruction at a time to the IF/ID register.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 12
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif

module if_fetch_unit #(
    parameter int                ADDR_W   = `ADDRESS_LEN,
    parameter int                INSTR_W  = `INSTRUCTION_LEN,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc_plus1,
    output logic [INSTR_W-1:0] if_instruction,
    output logic [15:0]        fetch_count,
    output logic [1:0]         dbg_state
);

    // Memory handshake: a request is accepted in the cycle imem_req && imem_gnt;
    // exactly one imem_rvalid pulse answers it, and only one request is ever in flight.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               squash_q, squash_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_plus1_q, pc_plus1_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        count_q, count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            squash_q   <= 1'b0;
            valid_q    <= 1'b0;
            pc_plus1_q <= '0;
            instr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            squash_q   <= squash_d;
            valid_q    <= valid_d;
            pc_plus1_q <= pc_plus1_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        valid_d    = valid_q;
        pc_plus1_d = pc_plus1_q;
        instr_d    = instr_q;
        count_d    = count_q;
        imem_req   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d = redirect_pc;
                    // Memory still took the old address; its answer must be dropped.
                    if (imem_gnt) begin
                        squash_d = 1'b1;
                        state_d  = S_WAIT;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d     = redirect_pc;
                    squash_d = 1'b1;
                end
                if (imem_rvalid) begin
                    if (squash_q || redirect) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        instr_d    = imem_rdata;
                        pc_plus1_d = pc_q + 1'b1;
                        valid_d    = 1'b1;
                        state_d    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    instr_d = '0;
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!id_stall) begin
                    count_d = count_q + 16'd1;
                    pc_d    = pc_q + 1'b1;
                    valid_d = 1'b0;
                    instr_d = '0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr      = pc_q;
    assign if_valid       = valid_q;
    assign if_pc_plus1    = pc_plus1_q;
    assign if_instruction = instr_q;
    assign fetch_count    = count_q;
    assign dbg_state      = state_q;

endmodule
